mem_req_arbiter: RTL
====================

# mem_req_arbiter

Merges the CPU core's instruction-fetch and data-access request channels onto one shared, variable-latency memory port. Sits directly below the core top, between its inst/data request interfaces and the memory/bus bridge. Grants one request per cycle, tracks up to OWN_DEPTH outstanding transactions in an owner FIFO, and routes in-order responses back to the issuing channel.

## Interface
- OWN_DEPTH, 4: max outstanding accepted-but-unanswered requests; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive data grants while inst is waiting before inst is forced to win; ≥1.
- clk  in  1  core clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_sram_req  in  1  fetch request valid.
- inst_sram_addr  in  32  fetch address.
- inst_sram_addr_ok  out  1  fetch request accepted this cycle.
- inst_sram_data_ok  out  1  fetch data valid, one-cycle pulse.
- inst_sram_rdata  out  32  fetch data.
- data_sram_req  in  1  data request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_wstrb  in  4  byte enables for stores.
- data_sram_addr  in  32  data address.
- data_sram_wdata  in  32  store data.
- data_sram_addr_ok  out  1  data request accepted this cycle.
- data_sram_data_ok  out  1  load data / store completion, one-cycle pulse.
- data_sram_rdata  out  32  load data.
- mem_req  out  1  request to memory.
- mem_we  out  4  byte write enables; 4'h0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_gnt  in  1  memory accepts current request.
- mem_rvalid  in  1  one response (read data or write ack), in request order.
- mem_rdata  in  32  response data.

## Operation
- Arbitration (combinational): data wins over inst unless starve counter == STARVE_LIMIT and inst_sram_req high; then inst wins.
- Starve counter: +1 on each data grant while inst_sram_req high; cleared on inst grant or cycle with inst_sram_req low; saturates at STARVE_LIMIT.
- mem_req = (inst_sram_req | data_sram_req) & ~fifo_full; held 0 while resetn low.
- mem_addr/mem_wdata from winner; mem_we = data_sram_wr ? data_sram_wstrb : 4'h0 for data, 4'h0 for inst. A store with wstrb 4'h0 is issued as a read; its response still pulses data_sram_data_ok.
- Accept = mem_req & mem_gnt. Winner's addr_ok = accept; loser's addr_ok = 0. Accept pushes owner bit (INST/DATA) into owner FIFO.
- mem_rvalid with FIFO non-empty: pop head; register data_ok for that owner and mem_rdata into that channel's rdata.
- mem_rvalid with FIFO empty: protocol error, ignored, no data_ok.
- fifo_full = (count == OWN_DEPTH). Push and pop in same cycle allowed when not full; a pop does not unblock a push in the same cycle.
- No cancellation: every accepted request receives exactly one data_ok.
- rdata registers hold last value between pulses.

## Timing
- Reset values: all data_ok 0, all rdata 32'h0, FIFO empty, count 0, starve counter 0; mem_req 0.
- addr_ok combinational from mem_gnt, same cycle.
- data_ok registered: cycle after mem_rvalid. Minimum round trip: accept at t, rvalid t+1, data_ok t+2.
- Throughput: one accept and one response per cycle sustained.
- Reset mid-operation: FIFO and counters cleared; stale mem_rvalid after release hits empty FIFO and is dropped.

## Structure
- Shared package: OWN_INST = 1'b0, OWN_DATA = 1'b1, MEM_ADDR_W = 32, MEM_DATA_W = 32.
- Sub-module owner_fifo: 1-bit-wide synchronous FIFO, depth OWN_DEPTH, push/pop/full/empty/count, async active-low reset.
- Arbiter, starve counter, and response registers stay in the top.

## Test plan
- Single load 0x100, mem_gnt=1, rvalid next cycle with 0xDEADBEEF -> data_sram_addr_ok at t, data_sram_data_ok at t+2, data_sram_rdata=0xDEADBEEF.
- Inst and data request same cycle, gnt=1 -> data accepted first, inst next cycle; responses A, B -> data gets A, inst gets B.
- mem_gnt=1, no rvalid, both requests held -> exactly 4 accepts (OWN_DEPTH=4), then mem_req=0; one rvalid -> mem_req reasserts the following cycle.
- Data and inst continuously requesting, gnt=1 -> inst granted after every 4 data grants.
- Store wstrb=4'b0011 to 0x200 -> mem_we=4'b0011, mem_wdata passes through; ack rvalid -> data_sram_data_ok pulse.
- Two requests outstanding, assert resetn=0 mid-flight, release, then two rvalids -> no data_ok, count stays 0.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
// Shared definitions for the instruction/data memory request arbiter.
//   OWN_INST / OWN_DATA : owner tags stored per outstanding transaction
//   MEM_ADDR_W / MEM_DATA_W : memory port address and data widths
package mem_req_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef logic owner_t;

    localparam owner_t OWN_INST = 1'b0;
    localparam owner_t OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// owner_fifo
// One-bit-wide synchronous FIFO recording which channel issued each
// outstanding memory request, so in-order responses can be routed back.
// Ports:
//   clk, resetn         : clock, asynchronous active-low reset
//   push, push_owner    : enqueue an owner tag (ignored when full)
//   pop                 : dequeue the head tag (ignored when empty)
//   head_owner          : owner tag at the head of the queue
//   full, empty, count  : occupancy status
module owner_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  owner_t                     push_owner,
    input  logic                       pop,
    output owner_t                     head_owner,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign head_owner = slots[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_owner;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Merges the core's instruction-fetch and data-access request channels onto
// a single variable-latency memory port. Data normally wins arbitration; a
// starvation counter forces a fetch through after STARVE_LIMIT consecutive
// data grants. Up to OWN_DEPTH accepted requests may be outstanding; their
// in-order responses are steered back to the issuing channel one cycle
// after mem_rvalid.
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   inst_sram_*                 : fetch request channel (req/addr/addr_ok/data_ok/rdata)
//   data_sram_*                 : data request channel (req/wr/wstrb/addr/wdata/addr_ok/data_ok/rdata)
//   mem_req/we/addr/wdata/gnt   : shared memory request port
//   mem_rvalid/rdata            : shared in-order memory response port
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int OWN_DEPTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_sram_req,
    input  logic [MEM_ADDR_W-1:0] inst_sram_addr,
    output logic                  inst_sram_addr_ok,
    output logic                  inst_sram_data_ok,
    output logic [MEM_DATA_W-1:0] inst_sram_rdata,
    input  logic                  data_sram_req,
    input  logic                  data_sram_wr,
    input  logic [3:0]            data_sram_wstrb,
    input  logic [MEM_ADDR_W-1:0] data_sram_addr,
    input  logic [MEM_DATA_W-1:0] data_sram_wdata,
    output logic                  data_sram_addr_ok,
    output logic                  data_sram_data_ok,
    output logic [MEM_DATA_W-1:0] data_sram_rdata,
    output logic                  mem_req,
    output logic [3:0]            mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]              starve_cnt;
    logic                       starved;
    logic                       inst_wins;
    logic                       accept;
    logic                       rsp_pop;
    owner_t                     head_owner;
    logic                       own_full;
    logic                       own_empty;
    logic [$clog2(OWN_DEPTH):0] unused_own_count;

    assign starved = (starve_cnt == SW'(STARVE_LIMIT));

    // Inst only wins when data is idle or the fetch side has been starved.
    assign inst_wins = inst_sram_req & (~data_sram_req | starved);

    // Gating with resetn keeps the port quiet while reset is held low,
    // independent of whatever the core drives on its request lines.
    assign mem_req   = (inst_sram_req | data_sram_req) & ~own_full & resetn;
    assign mem_addr  = inst_wins ? inst_sram_addr : data_sram_addr;
    assign mem_wdata = inst_wins ? '0 : data_sram_wdata;
    assign mem_we    = (!inst_wins && data_sram_wr) ? data_sram_wstrb : 4'h0;

    assign accept            = mem_req & mem_gnt;
    assign inst_sram_addr_ok = accept & inst_wins;
    assign data_sram_addr_ok = accept & ~inst_wins;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign rsp_pop = mem_rvalid & ~own_empty;

    owner_fifo #(
        .DEPTH (OWN_DEPTH)
    ) u_owner_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_owner (inst_wins ? OWN_INST : OWN_DATA),
        .pop        (rsp_pop),
        .head_owner (head_owner),
        .full       (own_full),
        .empty      (own_empty),
        .count      (unused_own_count)
    );

    // Counts data grants taken while a fetch is waiting; any cycle without a
    // pending fetch, or a fetch grant, restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!inst_sram_req || inst_sram_addr_ok) begin
            starve_cnt <= '0;
        end else if (data_sram_addr_ok && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Responses are registered: data_ok pulses the cycle after mem_rvalid,
    // and each channel's rdata holds its last value between pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_data_ok <= 1'b0;
            data_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= '0;
            data_sram_rdata   <= '0;
        end else begin
            inst_sram_data_ok <= rsp_pop & (head_owner == OWN_INST);
            data_sram_data_ok <= rsp_pop & (head_owner == OWN_DATA);
            if (rsp_pop && head_owner == OWN_INST) begin
                inst_sram_rdata <= mem_rdata;
            end
            if (rsp_pop && head_owner == OWN_DATA) begin
                data_sram_rdata <= mem_rdata;
            end
        end
    end

endmodule
